// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO.
package sync_fifo_pkg;

    function automatic int unsigned cnt_width(input int unsigned asize);
        return asize + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Single-clock storage: synchronous write port, combinational read port, no reset.
module sync_fifo_ram #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [1 << ASIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered reads.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE  = 8,
    parameter int unsigned ASIZE  = 4,
    parameter int unsigned AFULL  = (1 << ASIZE) - 2,
    parameter int unsigned AEMPTY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [DSIZE-1:0]             wdata,
    input  logic                         rd_en,
    output logic [DSIZE-1:0]             rdata,
    output logic                         rvalid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [cnt_width(ASIZE)-1:0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned CW    = cnt_width(ASIZE);

    logic [CW-1:0]    wptr;
    logic [CW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic             unf_q;
    logic             wr_ok;
    logic             rd_ok;
    logic [DSIZE-1:0] ram_rdata;
    fifo_status_t     status;

    // All flags come from the registered count, never from the pointers.
    always_comb begin
        status              = '0;
        status.full         = (count_q == CW'(DEPTH));
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= CW'(AFULL));
        status.almost_empty = (count_q <= CW'(AEMPTY));
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
    end

    assign wr_ok = wr_en && !status.full;
    assign rd_ok = rd_en && !status.empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            ovf_q <= wr_en && status.full;
            unf_q <= rd_en && status.empty;
        end
    end

    sync_fifo_ram #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wptr[ASIZE-1:0]),
        .wdata (wdata),
        .raddr (rptr[ASIZE-1:0]),
        .rdata (ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata  = ram_rdata;
    assign rvalid = !status.empty;
`else
    logic [DSIZE-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
            if (rd_ok) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
`endif

    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;
    assign count        = count_q;

    // The wrap bits make the pointer distance equal the occupancy at all times.
    a_ptr_count : assert property (@(posedge clk) disable iff (!rst_n)
        (CW'(wptr - rptr) == count_q));

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo with DSIZE=8, ASIZE=2, AFULL=3, AEMPTY=1.
module tb_sync_fifo;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int unsigned errors = 0;
    int unsigned checks = 0;

    sync_fifo #(
        .DSIZE  (8),
        .ASIZE  (2),
        .AFULL  (3),
        .AEMPTY (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one read of the head word and confirm it equals exp (rd_en left high).
    task automatic pop_check(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
        #0;
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check(tag, 32'(rdata), 32'(exp));
        tick();
`else
        tick();
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check(tag, 32'(rdata), 32'(exp));
`endif
    endtask

    logic [7:0] fill_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [2:0] fill_cnt  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic       fill_ae   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       fill_af   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       fill_full [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] drain_cnt [4] = '{3'd3, 3'd2, 3'd1, 3'd0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_rdata", 32'(rdata), 32'd0);
`endif

        // Fill
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wdata = fill_data[i];
            tick();
            check($sformatf("fill%0d_count", i), 32'(count), 32'(fill_cnt[i]));
            check($sformatf("fill%0d_aempty", i), 32'(almost_empty), 32'(fill_ae[i]));
            check($sformatf("fill%0d_afull", i), 32'(almost_full), 32'(fill_af[i]));
            check($sformatf("fill%0d_full", i), 32'(full), 32'(fill_full[i]));
            check($sformatf("fill%0d_empty", i), 32'(empty), 32'd0);
        end

        // Overflow on full
        wdata = 8'h55;
        tick();
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        wr_en = 1'b0;
        tick();
        check("ovf_clear", 32'(overflow), 32'd0);

        // Drain
        for (int i = 0; i < 4; i++) begin
            pop_check($sformatf("drain%0d", i), fill_data[i]);
            check($sformatf("drain%0d_count", i), 32'(count), 32'(drain_cnt[i]));
        end
        rd_en = 1'b0;
        tick();
        check("drain_empty", 32'(empty), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("drain_rvalid_low", 32'(rvalid), 32'd0);
        check("drain_rdata_hold", 32'(rdata), 32'h44);
`endif

        // Underflow: empty with both requests
        wr_en = 1'b1;
        rd_en = 1'b1;
        wdata = 8'hA5;
        tick();
        check("unf_pulse", 32'(underflow), 32'd1);
        check("unf_count", 32'(count), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("unf_rvalid", 32'(rvalid), 32'd0);
        check("unf_rdata_hold", 32'(rdata), 32'h44);
`endif
        wr_en = 1'b0;
        pop_check("unf_read", 8'hA5);
        check("unf_clear", 32'(underflow), 32'd0);
        check("unf_count0", 32'(count), 32'd0);
        rd_en = 1'b0;

        // Simultaneous read/write at count=2; pointers wrap past 2*DEPTH
        wr_en = 1'b1;
        wdata = 8'h01;
        tick();
        wdata = 8'h02;
        tick();
        check("sim_pre_count", 32'(count), 32'd2);
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1;
            wdata = 8'(i + 3);
            pop_check($sformatf("sim%0d", i), 8'(i + 1));
            check($sformatf("sim%0d_count", i), 32'(count), 32'd2);
        end
        wr_en = 1'b0;
        pop_check("sim_tail0", 8'h07);
        pop_check("sim_tail1", 8'h08);
        rd_en = 1'b0;
        tick();
        check("sim_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-burst
        wr_en = 1'b1;
        wdata = 8'h9A;
        tick();
        wdata = 8'h9B;
        tick();
        wdata = 8'h9C;
        rd_en = 1'b1;
        tick();
        check("burst_count", 32'(count), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_aempty", 32'(almost_empty), 32'd1);
        check("arst_rvalid", 32'(rvalid), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("arst_rdata", 32'(rdata), 32'd0);
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);

`ifdef SYNC_FIFO_FWFT_EN
        // First word falls through without a read request
        wr_en = 1'b1;
        wdata = 8'h3C;
        tick();
        wr_en = 1'b0;
        check("fwft_rvalid", 32'(rvalid), 32'd1);
        check("fwft_rdata", 32'(rdata), 32'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("fwft_pop_rvalid", 32'(rvalid), 32'd0);
        check("fwft_pop_empty", 32'(empty), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
